// File: rtl/chan_seq_pkg.sv
// -----------------------------------------------------------------------------
// chan_seq_pkg
// Shared definitions for the chan_sequencer block.
//   state_t    : sequencer FSM states (IDLE, DRIVE)
//   CH_*       : channel numbers as driven on the mux select lines
//   CNT_W      : width of the optional per-channel transfer counters
//   ch_onehot  : channel number -> one-hot ack vector (CH_NONE -> 0)
// -----------------------------------------------------------------------------
package chan_seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [1:0] CH_ALPHA = 2'd0;
  localparam logic [1:0] CH_BETA  = 2'd1;
  localparam logic [1:0] CH_GAMMA = 2'd2;
  localparam logic [1:0] CH_NONE  = 2'd3;

  localparam int CNT_W = 16;

  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    logic [2:0] oh;
    case (ch)
      CH_ALPHA: oh = 3'b001;
      CH_BETA:  oh = 3'b010;
      CH_GAMMA: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/chan_sequencer_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational three-way round-robin picker.
//   req   in  3 : request vector, bit n = channel n
//   last  in  2 : channel granted most recently (CH_NONE treated like gamma,
//                 so alpha has top priority)
//   grant out 2 : chosen channel, CH_NONE when nothing is requested
//   any   out 1 : at least one request present
// Search starts at (last+1) mod 3 and walks forward, skipping idle channels.
// -----------------------------------------------------------------------------
module rr_pick3
  import chan_seq_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       any
);

  // Search order for the current pointer: first, second, third candidate.
  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  always_comb begin
    first  = CH_ALPHA;
    second = CH_BETA;
    third  = CH_GAMMA;
    case (last)
      CH_ALPHA: begin
        first  = CH_BETA;
        second = CH_GAMMA;
        third  = CH_ALPHA;
      end
      CH_BETA: begin
        first  = CH_GAMMA;
        second = CH_ALPHA;
        third  = CH_BETA;
      end
      default: begin
        first  = CH_ALPHA;
        second = CH_BETA;
        third  = CH_GAMMA;
      end
    endcase
  end

  always_comb begin
    any   = |req;
    grant = CH_NONE;
    if (req[first])
      grant = first;
    else if (req[second])
      grant = second;
    else if (req[third])
      grant = third;
  end

endmodule

// File: rtl/chan_sequencer.sv
// -----------------------------------------------------------------------------
// chan_sequencer
// Sequences the alpha/beta/gamma sources through an external combinational
// 3-input select mux and captures the selected word into a one-entry
// valid/ready output register.
//
// Ports
//   clk          in  1       : clock, rising edge
//   nreset       in  1       : synchronous active-low reset
//   req          in  3       : level requests (bit0 alpha, bit1 beta, bit2 gamma)
//   ack          out 3       : one-hot pulse when a source's word is captured
//   sel          out 2       : mux select (3 = idle, mux returns 0)
//   cs           out 1       : mux chip-select, 1 forces mux output to 0
//   mux_out      in  DATA_W  : mux result, combinational from sel/cs
//   dout         out DATA_W  : captured word
//   dout_valid   out 1       : dout holds an unconsumed word
//   dout_ready   in  1       : downstream accepts dout
//   cnt_alpha/beta/gamma out 16 : per-channel transfer counters
//
// Build option
//   CHAN_SEQ_COUNT_EN : when defined, the cnt_* outputs are saturating
//                       counters of ack pulses; otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module chan_sequencer
  import chan_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [2:0]        req,
  output logic [2:0]        ack,
  output logic [1:0]        sel,
  output logic              cs,
  input  logic [DATA_W-1:0] mux_out,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  cnt_alpha,
  output logic [CNT_W-1:0]  cnt_beta,
  output logic [CNT_W-1:0]  cnt_gamma
);

  state_t            state_reg, state_next;
  logic [1:0]        sel_reg, sel_next;
  logic              cs_reg, cs_next;
  logic [2:0]        ack_reg, ack_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              dout_valid_reg, dout_valid_next;
  logic [1:0]        last_reg, last_next;

  logic [1:0]        pick_grant;
  logic              pick_any;
  logic              slot_free;

  rr_pick3 u_pick (
    .req   (req),
    .last  (last_reg),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // A pop on the grant edge empties the register before the DRIVE capture,
  // so a grant only needs the slot to be free at grant time.
  assign slot_free = !dout_valid_reg || dout_ready;

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    cs_next         = cs_reg;
    ack_next        = 3'b000;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    last_next       = last_reg;

    if (dout_valid_reg && dout_ready)
      dout_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        sel_next = CH_NONE;
        cs_next  = 1'b1;
        if (pick_any && slot_free) begin
          sel_next   = pick_grant;
          cs_next    = 1'b0;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        // sel_reg holds the committed grant; capture regardless of req now.
        dout_next       = mux_out;
        dout_valid_next = 1'b1;
        ack_next        = ch_onehot(sel_reg);
        last_next       = sel_reg;
        sel_next        = CH_NONE;
        cs_next         = 1'b1;
        state_next      = IDLE;
      end
      default: begin
        sel_next   = CH_NONE;
        cs_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg      <= IDLE;
      sel_reg        <= CH_NONE;
      cs_reg         <= 1'b1;
      ack_reg        <= 3'b000;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      last_reg       <= CH_GAMMA;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      cs_reg         <= cs_next;
      ack_reg        <= ack_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      last_reg       <= last_next;
    end
  end

  assign ack        = ack_reg;
  assign sel        = sel_reg;
  assign cs         = cs_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

`ifdef CHAN_SEQ_COUNT_EN
  logic [CNT_W-1:0] cnt_reg [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!nreset)
        cnt_reg[gi] <= '0;
      else if (ack_reg[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
    end
  end

  assign cnt_alpha = cnt_reg[0];
  assign cnt_beta  = cnt_reg[1];
  assign cnt_gamma = cnt_reg[2];
`else
  assign cnt_alpha = '0;
  assign cnt_beta  = '0;
  assign cnt_gamma = '0;
`endif

endmodule

// File: doc/chan_sequencer.md
# chan_sequencer

Sequencing stage that sits directly upstream of the asynchronous 3-input select mux: it arbitrates requests from the alpha, beta and gamma sources, drives the mux's `sel` and `cs` inputs, and captures the mux result into a one-entry output register with a valid/ready handshake. It converts the combinational mux into a registered, flow-controlled path. The rest of the datapath sees only `dout`/`dout_valid`.

## Interface
- `DATA_W`, 8: width of the mux data path and `dout`.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `nreset` in 1: synchronous, active-low reset.
- `req` in 3: request per source; bit 0 alpha, bit 1 beta, bit 2 gamma. Level; held until acked.
- `ack` out 3: one-hot, one-cycle pulse when that source's word is captured.
- `sel` out 2: mux select (0 alpha, 1 beta, 2 gamma, 3 idle/zero).
- `cs` out 1: mux chip-select; 1 forces mux output to 0, 0 enables it.
- `mux_out` in DATA_W: returned mux output, combinational from `sel`/`cs`.
- `dout` out DATA_W: captured word.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `dout_ready` in 1: downstream accepts `dout` when high with `dout_valid`.

## Operation
- FSM states: IDLE, DRIVE.
- Reset values: state IDLE, `sel`=3, `cs`=1, `ack`=0, `dout`=0, `dout_valid`=0, last-granted=2 (so alpha wins first).
- Slot free = `!dout_valid || dout_ready`.
- IDLE: `cs`=1, `sel`=3. If `|req` and slot free: pick grant by round-robin starting at (last+1) mod 3, skipping non-requesting sources; register `sel`<=grant, `cs`<=0; go DRIVE. Otherwise stay.
- DRIVE: `mux_out` is valid this cycle. Register `dout`<=`mux_out`, `dout_valid`<=1, `ack[grant]`<=1, last<=grant, `sel`<=3, `cs`<=1; go IDLE. Capture occurs even if `req[grant]` dropped during DRIVE (grant is committed).
- Output register: `dout_valid` clears on `dout_valid && dout_ready` unless loaded the same edge; `dout` stable while `dout_valid && !dout_ready`.
- Pop and grant in same IDLE cycle permitted; slot is empty by the DRIVE capture edge.
- `sel`=3 is never a grant value; mux result for 3 is 0 and never captured.
- `ack` is high only in the cycle following the DRIVE cycle; never two bits set.

## Timing
- `req` high at cycle N in IDLE, slot free → `sel`/`cs` driven at N+1 → `dout_valid` and `ack` high at N+2.
- Peak throughput: one word per 2 cycles with `dout_ready` held high.
- Backpressure: `dout_valid && !dout_ready` in IDLE blocks new grants indefinitely; `cs` stays 1.
- All requests held continuously: grant order alpha, beta, gamma, alpha, ...
- Reset asserted during DRIVE: capture aborted, no `ack`, all outputs to reset values next edge.
- `req` changes during DRIVE have no effect until next IDLE.

## Configuration
- `CHAN_SEQ_COUNT_EN` defined: three 16-bit saturating counters `cnt_alpha`, `cnt_beta`, `cnt_gamma` (outputs, 16 bits each) increment on the respective `ack` pulse, hold at 16'hFFFF, reset to 0.
- Not defined: counter ports present but tied to 0; no counter flops.

## Structure
- Package `chan_seq_pkg`: state enum (IDLE, DRIVE), channel constants CH_ALPHA=0, CH_BETA=1, CH_GAMMA=2, CH_NONE=3, counter width 16.
- Sub-module `rr_pick3`: combinational round-robin pick from 3-bit request and 2-bit last-granted; outputs 2-bit grant and `any` flag.

## Test plan
- Reset then `req`=3'b010, `mux_out` model returns beta=8'h5A → `sel`=1,`cs`=0 at N+1; `dout`=8'h5A, `dout_valid`=1, `ack`=3'b010 at N+2.
- `req`=3'b111 held, `dout_ready`=1 → `ack` sequence 001,010,100,001 every 2 cycles; `dout` alpha/beta/gamma values in that order.
- `dout_ready`=0 after first capture with `req`=3'b001 → no second grant, `cs`=1, `dout` held; raise `dout_ready` → new grant next cycle, second word at +2.
- Drop `req[0]` in DRIVE cycle → word still captured, `ack`=3'b001.
- Assert `nreset`=0 during DRIVE → no `ack`, `dout_valid`=0, `sel`=3, `cs`=1, next grant alpha.
- With `CHAN_SEQ_COUNT_EN`: 70000 gamma transfers → `cnt_gamma`=16'hFFFF, others 0.
